// File: rtl/spi_link_pkg.sv
// Shared SPI link constants: frame layout, header bytes, status bit positions, FSM encoding.
// Frame length depends on SPI_TX_CRC_EN (adds a trailing CRC-8 byte).
package spi_link_pkg;

    localparam logic [7:0]  HDR_NONCE    = 8'hA5;
    localparam logic [7:0]  HDR_EMPTY    = 8'h5A;
    localparam logic [7:0]  CRC8_POLY    = 8'h07;
    localparam int unsigned PAYLOAD_BITS = 48;

`ifdef SPI_TX_CRC_EN
    localparam int unsigned FRAME_BITS = PAYLOAD_BITS + 8;
`else
    localparam int unsigned FRAME_BITS = PAYLOAD_BITS;
`endif

    // Status byte: {pll_pdn, ovf_sticky, 3'b000, level[2:0]}
    localparam int unsigned STAT_PLL_BIT = 7;
    localparam int unsigned STAT_OVF_BIT = 6;
    localparam int unsigned STAT_LVL_MSB = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/spi_miso_nonce_tx_nonce_fifo.sv
// Synchronous nonce FIFO; DEPTH must be a power of 2 so pointers wrap naturally.
module nonce_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_miso_nonce_tx.sv
// MISO return path: buffers golden nonces and shifts one 48-bit frame per cs_n assertion.
// Define SPI_TX_CRC_EN to append a CRC-8 byte (56-bit frame).
module spi_miso_nonce_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  HDR_NONCE  = spi_link_pkg::HDR_NONCE,
    parameter logic [7:0]  HDR_EMPTY  = spi_link_pkg::HDR_EMPTY
) (
    input  logic        osc_clk,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        nonce_valid,
    input  logic [31:0] nonce_in,
    input  logic        pll_pdn,
    output logic        miso,
    output logic        miso_oe,
    output logic        frame_done
);

    import spi_link_pkg::*;

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    // [0] metastability flop, [1] synchronized level, [2] previous level for edge detect
    logic [2:0] cs_q, sclk_q;
    logic       cs_fall, cs_rise, sclk_fall;

    logic [1:0]            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]            bitcnt_q, bitcnt_d;
    logic                  has_nonce_q, has_nonce_d;
    logic                  ovf_rep_q, ovf_rep_d;
    logic                  ovf_q, ovf_d;

    logic                    fifo_full, fifo_empty, fifo_pop, commit;
    logic [LW-1:0]           fifo_level;
    logic [31:0]             fifo_head;
    logic [7:0]              level8, status;
    logic [PAYLOAD_BITS-1:0] payload;
    logic [FRAME_BITS-1:0]   frame;

    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            cs_q   <= '1;
            sclk_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], cs_n};
            sclk_q <= {sclk_q[1:0], sclk};
        end
    end

    assign cs_fall   =  cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] &  cs_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (osc_clk),
        .rst_n   (reset_n),
        .push_i  (nonce_valid),
        .data_i  (nonce_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

`ifdef SPI_TX_CRC_EN
    function automatic logic [7:0] crc8(input logic [PAYLOAD_BITS-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < PAYLOAD_BITS; i++) begin
            fb = c[7] ^ d[PAYLOAD_BITS-1-i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction
`endif

    always_comb begin
        level8 = 8'(fifo_level);
        status = '0;
        status[STAT_PLL_BIT]     = pll_pdn;
        status[STAT_OVF_BIT]     = ovf_q;
        status[STAT_LVL_MSB:0]   = (level8 > 8'd7) ? 3'd7 : level8[2:0];
        payload = {fifo_empty ? HDR_EMPTY : HDR_NONCE,
                   fifo_empty ? 32'h0 : fifo_head,
                   status};
`ifdef SPI_TX_CRC_EN
        frame = {payload, crc8(payload)};
`else
        frame = payload;
`endif
    end

    assign commit     = (state_q == ST_DONE);
    assign fifo_pop   = commit && has_nonce_q;
    assign frame_done = commit;
    assign miso_oe    = ~cs_q[1];
    assign miso       = miso_oe && (state_q == ST_SHIFT) && shreg_q[FRAME_BITS-1];

    always_comb begin
        ovf_d = ovf_q;
        if (commit && ovf_rep_q) ovf_d = 1'b0;
        // A new overflow outranks clearing the one just reported.
        if (nonce_valid && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        has_nonce_d = has_nonce_q;
        ovf_rep_d   = ovf_rep_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_LOAD;
            ST_LOAD: begin
                shreg_d     = frame;
                bitcnt_d    = '0;
                has_nonce_d = ~fifo_empty;
                ovf_rep_d   = ovf_q;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: if (sclk_fall) begin
                if (bitcnt_q == 6'(FRAME_BITS-1)) begin
                    state_d = ST_DONE;
                end else begin
                    shreg_d  = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge osc_clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            has_nonce_q <= 1'b0;
            ovf_rep_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            has_nonce_q <= has_nonce_d;
            ovf_rep_q   <= ovf_rep_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_miso_nonce_tx.sv
// Directed bench for spi_miso_nonce_tx: table of frames plus hand-written commit/push race.
// Honours SPI_TX_CRC_EN for the 56-bit frame variant.
module tb_spi_miso_nonce_tx;

`ifdef SPI_TX_CRC_EN
    localparam int FB = 56;
`else
    localparam int FB = 48;
`endif

    logic        osc_clk = 1'b0;
    logic        reset_n, cs_n, sclk, nonce_valid, pll_pdn;
    logic [31:0] nonce_in;
    logic        miso, miso_oe, frame_done;

    int checks = 0;
    int errors = 0;
    int done_seen;
    bit arm_push = 1'b0;
    logic [31:0] arm_val;
    logic oe_mid, oe_after, miso_after;

    always #5 osc_clk = ~osc_clk;

    spi_miso_nonce_tx #(
        .FIFO_DEPTH (4),
        .HDR_NONCE  (8'hA5),
        .HDR_EMPTY  (8'h5A)
    ) dut (
        .osc_clk     (osc_clk),
        .reset_n     (reset_n),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .nonce_valid (nonce_valid),
        .nonce_in    (nonce_in),
        .pll_pdn     (pll_pdn),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .frame_done  (frame_done)
    );

    typedef struct {
        int          npush;
        logic [31:0] base;
        int          nbits;   // bits clocked before cs_n rises; < FB means abort
        logic [47:0] exp;     // header, nonce, status
        int          exp_done;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [7:0] ref_crc8(input logic [47:0] d);
        logic [7:0] c = 8'h00;
        for (int i = 47; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [55:0] full_frame(input logic [47:0] p);
`ifdef SPI_TX_CRC_EN
        return {p, ref_crc8(p)};
`else
        return {8'h00, p};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge osc_clk);
        if (nonce_valid) nonce_valid = 1'b0;
        if (frame_done) begin
            done_seen++;
            if (arm_push) begin
                nonce_valid = 1'b1;
                nonce_in    = arm_val;
                arm_push    = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [31:0] v);
        @(negedge osc_clk);
        nonce_valid = 1'b1;
        nonce_in    = v;
        @(negedge osc_clk);
        nonce_valid = 1'b0;
    endtask

    task automatic run_frame(input int nb, output logic [55:0] g, output int dn);
        g = '0;
        done_seen = 0;
        cs_n = 1'b0;
        repeat (6) tick();
        oe_mid = miso_oe;
        for (int i = 0; i < nb; i++) begin
            g = {g[54:0], miso};
            sclk = 1'b1;
            repeat (4) tick();
            sclk = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (6) tick();
        oe_after   = miso_oe;
        miso_after = miso;
        dn = done_seen;
    endtask

    initial begin
        logic [55:0] got, efr;
        int dn;

        vecs[0]  = '{0, 32'h0,        FB, 48'h5A_00000000_80, 1};
        vecs[1]  = '{1, 32'hDEADBEEF, FB, 48'hA5_DEADBEEF_81, 1};
        vecs[2]  = '{0, 32'h0,        FB, 48'h5A_00000000_80, 1};
        vecs[3]  = '{5, 32'h00000001, FB, 48'hA5_00000001_C4, 1};
        vecs[4]  = '{0, 32'h0,        FB, 48'hA5_00000002_83, 1};
        vecs[5]  = '{0, 32'h0,        FB, 48'hA5_00000003_82, 1};
        vecs[6]  = '{0, 32'h0,        FB, 48'hA5_00000004_81, 1};
        vecs[7]  = '{0, 32'h0,        FB, 48'h5A_00000000_80, 1};
        vecs[8]  = '{1, 32'h12345678, 20, 48'hA5_12345678_81, 0};
        vecs[9]  = '{0, 32'h0,        FB, 48'hA5_12345678_81, 1};
        vecs[10] = '{0, 32'h0,        FB, 48'h5A_00000000_80, 1};

        reset_n = 1'b0; cs_n = 1'b1; sclk = 1'b0;
        nonce_valid = 1'b0; nonce_in = '0; pll_pdn = 1'b1;
        repeat (4) @(negedge osc_clk);
        chk("reset_miso", 64'(miso), 64'd0);
        chk("reset_oe", 64'(miso_oe), 64'd0);
        chk("reset_done", 64'(frame_done), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge osc_clk);
        chk("idle_oe", 64'(miso_oe), 64'd0);

        for (int v = 0; v < 11; v++) begin
            for (int p = 0; p < vecs[v].npush; p++) push(vecs[v].base + 32'(p));
            run_frame(vecs[v].nbits, got, dn);
            efr = full_frame(vecs[v].exp) >> (FB - vecs[v].nbits);
            chk($sformatf("vec%0d_bits", v), 64'(got), 64'(efr));
            chk($sformatf("vec%0d_done", v), 64'(dn), 64'(vecs[v].exp_done));
            if (v == 0) begin
                chk("oe_during_frame", 64'(oe_mid), 64'd1);
                chk("oe_after_frame", 64'(oe_after), 64'd0);
                chk("miso_after_frame", 64'(miso_after), 64'd0);
            end
        end

        // Push into a full FIFO on the exact cycle the frame commits: no overflow.
        for (int p = 0; p < 4; p++) push(32'hC0DE0000 + 32'(p));
        arm_val  = 32'hFEEDF00D;
        arm_push = 1'b1;
        run_frame(FB, got, dn);
        chk("race_frame", 64'(got), 64'(full_frame(48'hA5_C0DE0000_84)));
        chk("race_push_fired", 64'(arm_push), 64'd0);
        run_frame(FB, got, dn);
        chk("race_next_frame", 64'(got), 64'(full_frame(48'hA5_C0DE0001_84)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
